// File: rtl/dvs_event_buffered_bus_writer_if.sv
// Handshake and status bundle between the event source/bus arbiter side and the buffered writer.
// master drives events, grants and clears; slave returns the bus write and occupancy/drop statistics.
interface dvs_event_buffered_bus_writer_if #(
  parameter int EVENT_BITS    = 32,
  parameter int BUF_DEPTH     = 4,
  parameter int DROP_CNT_BITS = 16
);
  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic                     in_valid;
  logic [EVENT_BITS-1:0]    in_event;
  logic                     in_filtered;
  logic                     fifo_grant;
  logic                     clr_stats;
  logic                     fifo_req;
  logic                     fifo_wr_en;
  logic [EVENT_BITS-1:0]    fifo_event;
  logic [CNT_W-1:0]         buf_count;
  logic [DROP_CNT_BITS-1:0] drop_count;
  logic                     overflow;

  modport master (
    output in_valid, in_event, in_filtered, fifo_grant, clr_stats,
    input  fifo_req, fifo_wr_en, fifo_event, buf_count, drop_count, overflow
  );

  modport slave (
    input  in_valid, in_event, in_filtered, fifo_grant, clr_stats,
    output fifo_req, fifo_wr_en, fifo_event, buf_count, drop_count, overflow
  );
endinterface

// File: rtl/dvs_event_buffered_bus_writer.sv
// Queues unfiltered DVS events in a BUF_DEPTH circular buffer and writes them to the shared FIFO bus.
// Write strobe is registered one cycle after grant; a full buffer drops new events and counts them.
module dvs_event_buffered_bus_writer #(
  parameter int EVENT_BITS    = 32,
  parameter int BUF_DEPTH     = 4,
  parameter int DROP_CNT_BITS = 16
) (
  input logic clk,
  input logic rst,
  dvs_event_buffered_bus_writer_if.slave bus
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [EVENT_BITS-1:0]    r_buf [BUF_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [CNT_W-1:0]         r_count;
  logic                     r_wr_en;
  logic [EVENT_BITS-1:0]    r_event;
  logic [DROP_CNT_BITS-1:0] r_drop;
  logic                     r_ovf;

  logic w_pop;
  logic w_push_req;
  logic w_full;
  logic w_push_acc;
  logic w_drop;
  logic w_drop_sat;

  assign w_pop      = bus.fifo_grant && (r_count != '0);
  assign w_push_req = bus.in_valid && !bus.in_filtered;
  assign w_full     = (r_count == CNT_W'(BUF_DEPTH));
  // A full buffer still accepts when the same cycle frees a slot.
  assign w_push_acc = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_drop_sat = &r_drop;

  always_ff @(posedge clk) begin
    if (w_push_acc) begin
      r_buf[r_wr_ptr] <= bus.in_event;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_wr_en  <= 1'b0;
      r_event  <= '0;
      r_drop   <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_event  <= r_buf[r_rd_ptr];
      end
      r_wr_en <= w_pop;
      r_count <= r_count + CNT_W'(w_push_acc) - CNT_W'(w_pop);

      // A drop coinciding with a clear survives as the first post-clear drop.
      if (bus.clr_stats) begin
        r_drop <= w_drop ? DROP_CNT_BITS'(1) : '0;
        r_ovf  <= w_drop;
      end else if (w_drop) begin
        r_ovf <= 1'b1;
        if (!w_drop_sat) begin
          r_drop <= r_drop + DROP_CNT_BITS'(1);
        end
      end
    end
  end

  assign bus.fifo_req   = (r_count != '0);
  assign bus.fifo_wr_en = r_wr_en;
  assign bus.fifo_event = r_event;
  assign bus.buf_count  = r_count;
  assign bus.drop_count = r_drop;
  assign bus.overflow   = r_ovf;
endmodule

// File: doc/dvs_event_buffered_bus_writer.md
Name: dvs_event_buffered_bus_writer

Overview:
Parametrised successor to the single-event AER-to-FIFO-bus stage. It accepts preprocessed DVS events and drops filtered ones. Accepted events are queued in a local circular buffer of BUF_DEPTH entries, so bursts from the camera are not lost while the shared FIFO bus is busy. It sits between dvs_event_preprocessor and the shared FIFO bus arbiter, and reports buffer occupancy and dropped-event statistics.

Parameters:
EVENT_BITS, 32, width of one packed event word on the FIFO bus.
BUF_DEPTH, 4, local buffer entries; power of two, >= 2.
DROP_CNT_BITS, 16, width of the saturating dropped-event counter.

Ports:
clk  in  1  system clock; all state updates on its rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  one-cycle pulse: in_event/in_filtered are valid this cycle
in_event  in  EVENT_BITS  preprocessed event word
in_filtered  in  1  event rejected by preprocessor; qualified by in_valid
fifo_grant  in  1  bus arbiter grant, one cycle per granted write
clr_stats  in  1  synchronous clear of drop_count and overflow
fifo_req  out  1  bus request
fifo_wr_en  out  1  write strobe on shared bus
fifo_event  out  EVENT_BITS  event word on shared bus
buf_count  out  $clog2(BUF_DEPTH)+1  current buffer occupancy
drop_count  out  DROP_CNT_BITS  events lost to buffer overflow, saturating
overflow  out  1  sticky: at least one event dropped since last clear/reset

Behaviour:
- Reset (rst high, async): wr_ptr=rd_ptr=0; buf_count=0; fifo_req=0; fifo_wr_en=0; fifo_event=0; drop_count=0; overflow=0. Buffer contents are don't-care.
- Reset asserted mid-operation discards all queued events. Any write strobe in flight is cancelled immediately.
- Pointers are $clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. Occupancy is held in buf_count, not inferred from the pointers.
- pop = fifo_grant && (buf_count != 0). A grant while empty is ignored: no pop, fifo_wr_en=0 next cycle.
- push_req = in_valid && !in_filtered. An event with in_filtered=1 is discarded silently and is not counted as a drop.
- Push is accepted when buf_count < BUF_DEPTH, or when buf_count == BUF_DEPTH and pop occurs in the same cycle (full + simultaneous pop/push: count unchanged).
- On an accepted push: buf[wr_ptr] <= in_event and wr_ptr increments.
- On pop: fifo_event <= buf[rd_ptr], fifo_wr_en <= 1 (registered, one cycle after grant), and rd_ptr increments.
- With no pop: fifo_wr_en <= 0 and fifo_event holds its last value.
- buf_count next = buf_count + push_accepted − pop.
- fifo_req = (buf_count != 0), combinational from registered count.
  - If a grant pops the last entry, fifo_req is high in the grant cycle and low the next cycle, unless a push lands in that same cycle.
- Latency: with an empty buffer and in_valid at cycle t, buf_count=1 and fifo_req=1 at t+1. Grant at t+1 gives fifo_wr_en=1 with that event at t+2.
- Ordering is strict FIFO. Back-to-back grants on consecutive cycles drain one entry per cycle.
- Drop: push_req when full with no pop.
  - overflow <= 1.
  - drop_count increments, saturating at 2^DROP_CNT_BITS−1.
- clr_stats: drop_count <= 0 and overflow <= 0.
  - If a drop occurs in the same cycle: drop_count <= 1 and overflow <= 1.
  - clr_stats does not affect buffer contents.
- No combinational path from in_valid/in_event to any output.

Test Plan:
- Reset behaviour: hold rst=1 for 3 cycles with random inputs -> all outputs 0. Release rst, single in_valid with event 0x0000_1234 and grant tied high -> fifo_req at t+1, fifo_wr_en=1 with fifo_event=0x0000_1234 at t+2, then fifo_req=0.
- Filtering: 5 in_valid pulses with in_filtered=1 -> buf_count stays 0, fifo_req never asserts, drop_count=0.
- Burst and overflow: BUF_DEPTH=4, no grant, 6 events 1..6 -> buf_count=4, drop_count=2, overflow=1. Then grant 4 cycles -> fifo_event sequence 1,2,3,4 on consecutive wr_en cycles.
- Full with simultaneous push and pop: buffer full with 1..4; event 5 arrives in a grant cycle -> no drop, buf_count stays 4. Drain order is 1,2,3,4,5.
- Wrap and idle grant: 10 push/pop interleaved cycles spanning pointer wrap -> FIFO order preserved. A grant while empty gives fifo_wr_en=0 and fifo_event unchanged.
- Stats: DROP_CNT_BITS=2, 5 drops -> drop_count saturates at 3. clr_stats coinciding with a drop -> drop_count=1, overflow=1. Reset asserted with 3 entries queued -> buf_count=0, fifo_req=0 immediately.
